// File: rtl/mult_bin2bcd.sv
// Sequential double-dabble binary-to-BCD converter fed by the shift-add multiplier.
// A rising edge on i_init starts one conversion; o_done pulses when o_bcd_out/o_overflow update.
module mult_bin2bcd #(
    parameter int BIN_W  = 33,
    parameter int DIGITS = 10
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_init,
    input  logic [BIN_W-1:0]      i_bin_in,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [4*DIGITS-1:0]   o_bcd_out,
    output logic                  o_overflow
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(BIN_W + 1);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(BIN_W);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_ADD3,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t             r_state;
    logic               r_init_q;
    logic [CNT_W-1:0]   r_cnt;
    logic [BIN_W-1:0]   r_bin_sr;
    logic [BCD_W-1:0]   r_bcd_sr;
    logic               r_ovf_sticky;

    logic               w_start;
    logic [BCD_W-1:0]   w_bcd_add3;

    assign w_start = (r_state == S_IDLE) && i_init && !r_init_q;

    // Per-digit correction so the following left shift carries into the next decade.
    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_add3
            assign w_bcd_add3[4*gi +: 4] = (r_bcd_sr[4*gi +: 4] >= 4'd5)
                                         ? r_bcd_sr[4*gi +: 4] + 4'd3
                                         : r_bcd_sr[4*gi +: 4];
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_init_q     <= 1'b1;   // a level held through reset release must not start a run
            r_cnt        <= '0;
            r_bin_sr     <= '0;
            r_bcd_sr     <= '0;
            r_ovf_sticky <= 1'b0;
            o_busy       <= 1'b0;
            o_done       <= 1'b0;
            o_bcd_out    <= '0;
            o_overflow   <= 1'b0;
        end else begin
            r_init_q <= i_init;
            case (r_state)
                S_IDLE: begin
                    o_done <= 1'b0;
                    if (w_start) begin
                        r_state <= S_LOAD;
                        o_busy  <= 1'b1;
                    end
                end
                S_LOAD: begin
                    r_bin_sr     <= i_bin_in;
                    r_bcd_sr     <= '0;
                    r_ovf_sticky <= 1'b0;
                    r_cnt        <= CNT_INIT;
                    r_state      <= S_ADD3;
                end
                S_ADD3: begin
                    r_bcd_sr <= w_bcd_add3;
                    r_state  <= S_SHIFT;
                end
                S_SHIFT: begin
                    // The bit leaving the top digit is the carry past the last decade.
                    {r_bcd_sr, r_bin_sr} <= {r_bcd_sr[BCD_W-2:0], r_bin_sr, 1'b0};
                    r_ovf_sticky <= r_ovf_sticky | r_bcd_sr[BCD_W-1];
                    r_cnt        <= r_cnt - 1'b1;
                    r_state      <= (r_cnt == CNT_W'(1)) ? S_DONE : S_ADD3;
                end
                S_DONE: begin
                    o_bcd_out  <= r_bcd_sr;
                    o_overflow <= r_ovf_sticky;
                    o_done     <= 1'b1;
                    o_busy     <= 1'b0;
                    r_state    <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                    o_busy  <= 1'b0;
                    o_done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mult_bin2bcd.sv
// Self-checking bench for mult_bin2bcd: a 10-digit instance and a 4-digit instance for overflow,
// checked against a decimal reference model built from plain division.
module tb_mult_bin2bcd;

    localparam int BIN_W = 33;
    localparam int LAT   = 2 * BIN_W + 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        init, init4;
    logic [32:0] bin, bin4;
    logic        busy, done, ovf_o;
    logic [39:0] bcd_out;
    logic        busy4, done4, ovf4;
    logic [15:0] bcd4_out;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mult_bin2bcd #(.BIN_W(BIN_W), .DIGITS(10)) dut (
        .clk(clk), .reset(reset), .i_init(init), .i_bin_in(bin),
        .o_busy(busy), .o_done(done), .o_bcd_out(bcd_out), .o_overflow(ovf_o)
    );

    mult_bin2bcd #(.BIN_W(BIN_W), .DIGITS(4)) dut4 (
        .clk(clk), .reset(reset), .i_init(init4), .i_bin_in(bin4),
        .o_busy(busy4), .o_done(done4), .o_bcd_out(bcd4_out), .o_overflow(ovf4)
    );

    // Decimal digits of v, least significant first, truncated to nd digits.
    function automatic logic [39:0] ref_bcd(input longint unsigned v, input int nd);
        logic [39:0] r = '0;
        for (int i = 0; i < nd; i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    function automatic logic ref_ovf(input longint unsigned v, input int nd);
        longint unsigned lim = 1;
        for (int i = 0; i < nd; i++) lim = lim * 10;
        return v >= lim;
    endfunction

    // Starts one conversion at the current negedge and waits for done (bounded).
    task automatic do_conv(input bit sel4, input logic [32:0] val,
                           output logic [39:0] got_bcd, output logic got_ovf,
                           output int lat, output bit busy_ok);
        bit seen = 0;
        if (sel4) begin bin4 = val; init4 = 1'b1; end
        else      begin bin  = val; init  = 1'b1; end
        busy_ok = 1; lat = -1; got_bcd = '0; got_ovf = 1'b0;
        for (int k = 1; k <= 200 && !seen; k++) begin
            @(negedge clk);
            if (k == 1) begin init = 1'b0; init4 = 1'b0; end
            if (sel4 ? done4 : done) begin
                seen    = 1;
                lat     = k - 1;
                got_bcd = sel4 ? {24'h0, bcd4_out} : bcd_out;
                got_ovf = sel4 ? ovf4 : ovf_o;
                if (sel4 ? busy4 : busy) busy_ok = 0;
            end else if (!(sel4 ? busy4 : busy)) begin
                busy_ok = 0;
            end
        end
    endtask

    task automatic test_reset();
        init = 1'b1; init4 = 1'b1; bin = '0; bin4 = '0;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0)     begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
        checks++; if (bcd_out !== 40'h0) begin errors++; $display("FAIL reset_bcd got=%h exp=0", bcd_out); end
        checks++; if (ovf_o !== 1'b0)    begin errors++; $display("FAIL reset_ovf got=%b exp=0", ovf_o); end
        reset = 1'b0;
        repeat (5) @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_held_init_no_start busy=%b exp=0", busy); end
        init = 1'b0; init4 = 1'b0;
        @(negedge clk);
        $display("test_reset done");
    endtask

    task automatic test_zero();
        logic [39:0] b; logic o; int lat; bit bok;
        do_conv(0, 33'd0, b, o, lat, bok);
        $display("conv val=0 bcd=%h ovf=%b lat=%0d", b, o, lat);
        checks++; if (lat != LAT)   begin errors++; $display("FAIL zero_latency got=%0d exp=%0d", lat, LAT); end
        checks++; if (b !== 40'h0)  begin errors++; $display("FAIL zero_bcd got=%h exp=0", b); end
        checks++; if (o !== 1'b0)   begin errors++; $display("FAIL zero_ovf got=%b exp=0", o); end
        checks++; if (!bok)         begin errors++; $display("FAIL zero_busy got=bad exp=high_until_done"); end
    endtask

    task automatic test_corners();
        logic [32:0] vals [3] = '{33'd65025, 33'h1_FFFF_FFFF, 33'h0_FFFF_FFFF};
        logic [39:0] b, e; logic o; int lat; bit bok;
        foreach (vals[i]) begin
            e = ref_bcd(longint'(vals[i]), 10);
            do_conv(0, vals[i], b, o, lat, bok);
            $display("conv val=%0d bcd=%h exp=%h lat=%0d", vals[i], b, e, lat);
            checks++; if (b !== e)    begin errors++; $display("FAIL corner_bcd val=%0d got=%h exp=%h", vals[i], b, e); end
            checks++; if (o !== 1'b0) begin errors++; $display("FAIL corner_ovf val=%0d got=%b exp=0", vals[i], o); end
            checks++; if (lat != LAT) begin errors++; $display("FAIL corner_latency got=%0d exp=%0d", lat, LAT); end
        end
    endtask

    task automatic test_random();
        logic [32:0] v; logic [39:0] b, e; logic o; int lat; bit bok;
        for (int i = 0; i < 10; i++) begin
            v = {1'($urandom), 32'($urandom)};
            if (i % 3 == 1) v = 33'($urandom_range(0, 99999));
            e = ref_bcd(longint'(v), 10);
            do_conv(0, v, b, o, lat, bok);
            $display("conv val=%0d bcd=%h exp=%h", v, b, e);
            checks++; if (b !== e || o !== 1'b0) begin errors++; $display("FAIL random_bcd val=%0d got=%h/%b exp=%h/0", v, b, o, e); end
        end
    endtask

    task automatic test_overflow();
        logic [32:0] vals [6];
        logic [39:0] b, e; logic o, eo; int lat; bit bok;
        vals = '{33'd12345, 33'd9999, 33'd10000, 33'h1_FFFF_FFFF, 33'($urandom), 33'($urandom_range(0, 9999))};
        foreach (vals[i]) begin
            e  = ref_bcd(longint'(vals[i]), 4);
            eo = ref_ovf(longint'(vals[i]), 4);
            do_conv(1, vals[i], b, o, lat, bok);
            $display("conv4 val=%0d bcd=%h ovf=%b exp=%h/%b", vals[i], b[15:0], o, e[15:0], eo);
            checks++; if (b !== e)  begin errors++; $display("FAIL ovf_bcd val=%0d got=%h exp=%h", vals[i], b[15:0], e[15:0]); end
            checks++; if (o !== eo) begin errors++; $display("FAIL ovf_flag val=%0d got=%b exp=%b", vals[i], o, eo); end
        end
    endtask

    task automatic test_back_to_back();
        logic [32:0] v1, v2; logic [39:0] b1, b2; logic o1, o2; int l1, l2; bit k1, k2;
        v1 = {1'($urandom), 32'($urandom)};
        v2 = {1'($urandom), 32'($urandom)};
        do_conv(0, v1, b1, o1, l1, k1);
        do_conv(0, v2, b2, o2, l2, k2);
        $display("b2b v1=%0d bcd=%h v2=%0d bcd=%h lat2=%0d", v1, b1, v2, b2, l2);
        checks++; if (b1 !== ref_bcd(longint'(v1), 10)) begin errors++; $display("FAIL b2b_first got=%h exp=%h", b1, ref_bcd(longint'(v1), 10)); end
        checks++; if (b2 !== ref_bcd(longint'(v2), 10)) begin errors++; $display("FAIL b2b_second got=%h exp=%h", b2, ref_bcd(longint'(v2), 10)); end
        checks++; if (l2 != LAT) begin errors++; $display("FAIL b2b_latency got=%0d exp=%0d", l2, LAT); end
    endtask

    // Long init level, a second pulse while busy, and bin_in changed after LOAD.
    task automatic test_held_init(input bit hold_all);
        logic [32:0] v1, v2; logic [39:0] got, e; int dones = 0;
        v1 = {1'($urandom), 32'($urandom)};
        v2 = ~v1;
        e  = ref_bcd(longint'(v1), 10);
        got = '0;
        bin = v1; init = 1'b1;
        for (int c = 1; c <= 160; c++) begin
            @(negedge clk);
            if (!hold_all) begin
                if (c == 10) init = 1'b0;
                if (c == 20) init = 1'b1;
                if (c == 21) init = 1'b0;
            end
            if (c == 12) bin = v2;
            if (done) begin dones++; got = bcd_out; end
        end
        init = 1'b0;
        @(negedge clk);
        $display("held_init hold_all=%0d dones=%0d bcd=%h exp=%h", hold_all, dones, got, e);
        checks++; if (dones != 1) begin errors++; $display("FAIL held_init_dones got=%0d exp=1", dones); end
        checks++; if (got !== e)  begin errors++; $display("FAIL held_init_bcd got=%h exp=%h", got, e); end
    endtask

    task automatic test_reset_mid();
        logic [32:0] v; logic [39:0] b; logic o; int lat, dones = 0, busies = 0; bit bok;
        bin = {1'($urandom), 32'($urandom)}; init = 1'b1;
        repeat (30) @(negedge clk);
        reset = 1'b1;
        #1;
        checks++; if (busy !== 1'b0 || done !== 1'b0 || bcd_out !== 40'h0 || ovf_o !== 1'b0) begin
            errors++; $display("FAIL reset_mid_outputs got=%b/%b/%h/%b exp=0/0/0/0", busy, done, bcd_out, ovf_o);
        end
        @(negedge clk);
        reset = 1'b0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (done) dones++;
            if (busy) busies++;
        end
        checks++; if (dones != 0 || busies != 0) begin errors++; $display("FAIL reset_mid_no_restart dones=%0d busy_cycles=%0d exp=0/0", dones, busies); end
        init = 1'b0;
        @(negedge clk);
        v = 33'($urandom_range(0, 999999));
        do_conv(0, v, b, o, lat, bok);
        $display("reset_mid restart val=%0d bcd=%h", v, b);
        checks++; if (b !== ref_bcd(longint'(v), 10)) begin errors++; $display("FAIL reset_mid_restart got=%h exp=%h", b, ref_bcd(longint'(v), 10)); end
    endtask

    initial begin
        test_reset();
        test_zero();
        test_corners();
        test_random();
        test_overflow();
        test_back_to_back();
        test_held_init(0);
        test_held_init(1);
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
